// File: rtl/sync_fifo_param_if.sv
// Producer/consumer signal bundle for sync_fifo_param.
// overflow/underflow exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );
`else
  modport master (
    output wr_en, din, rd_en,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count and almost flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THRESH = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              rd_valid_reg;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Extra pointer MSB separates "same index, one lap apart" (full) from equal (empty).
  assign full   = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                  (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      dout_reg     <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        dout_reg   <= mem[rd_ptr_reg[ADDR_W-1:0]];
      end
      if (wr_acc && !rd_acc) begin
        count_reg <= count_reg + PTR_ONE;
      end else if (rd_acc && !wr_acc) begin
        count_reg <= count_reg - PTR_ONE;
      end
    end
  end

  assign bus.dout         = dout_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_reg;
  assign bus.almost_full  = (count_reg >= AF_THRESH);
  assign bus.almost_empty = (count_reg <= AE_THRESH);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky until reset so software can poll after the fact.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed-vector bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Error-flag checks are compiled in when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; expected state comes from a reference queue.
  task automatic op(input logic wr, input logic rd, input logic [7:0] data);
    bit wr_ok;
    bit rd_ok;
    int n;
    n     = model_q.size();
    wr_ok = wr && (n < DEPTH);
    rd_ok = rd && (n > 0);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = data;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    if (rd_ok) exp_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(data);
    n = model_q.size();
    $display("op wr=%0b rd=%0b din=%02h -> count=%0d dout=%02h rd_valid=%0b",
             wr, rd, data, bus.count, bus.dout, bus.rd_valid);
    check("count",        32'(bus.count),    32'(n));
    check("rd_valid",     32'(bus.rd_valid), 32'(rd_ok));
    check("dout",         32'(bus.dout),     32'(exp_dout));
    check("full",         32'(bus.full),     32'(n == DEPTH));
    check("empty",        32'(bus.empty),    32'(n == 0));
    check("almost_full",  32'(bus.almost_full),  32'(n >= 14));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    rst       = 1'b1;
    exp_dout  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    $display("reset released");
    check("rst_count",    32'(bus.count),        32'd0);
    check("rst_empty",    32'(bus.empty),        32'd1);
    check("rst_full",     32'(bus.full),         32'd0);
    check("rst_ae",       32'(bus.almost_empty), 32'd1);
    check("rst_af",       32'(bus.almost_full),  32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid),     32'd0);
    check("rst_dout",     32'(bus.dout),         32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
`endif

    // Fill 0x11..0x20, then a dropped write of 0xAA.
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i + 'h11));
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full",  32'(bus.full),  32'd1);
    op(1'b1, 1'b0, 8'hAA);
    check("ovf_count", 32'(bus.count), 32'd16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow_set",  32'(bus.overflow),  32'd1);
    check("underflow_clr", 32'(bus.underflow), 32'd0);
`endif

    // Drain, then read while empty.
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 8'h00);
    check("drain_last", 32'(bus.dout),  32'h20);
    check("drain_empty", 32'(bus.empty), 32'd1);
    op(1'b0, 1'b1, 8'h00);
    check("udf_dout",     32'(bus.dout),     32'h20);
    check("udf_rd_valid", 32'(bus.rd_valid), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("underflow_set", 32'(bus.underflow), 32'd1);
`endif

    // Pointers now lap through index 15 -> 0.
    for (int i = 0; i < 12; i++) op(1'b1, 1'b0, 8'(i + 'h30));
    for (int i = 0; i < 12; i++) op(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(i + 'h40));
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, 8'h00);
    check("wrap_dout",  32'(bus.dout),  32'h49);
    check("wrap_count", 32'(bus.count), 32'd0);

    // Streaming at count=5.
    for (int i = 0; i < 5; i++)  op(1'b1, 1'b0, 8'(i + 'h60));
    for (int i = 0; i < 20; i++) op(1'b1, 1'b1, 8'(i + 'h65));
    check("stream_count", 32'(bus.count), 32'd5);
    check("stream_dout",  32'(bus.dout),  32'h73);

    // wr+rd at full drops the write.
    for (int i = 0; i < 11; i++) op(1'b1, 1'b0, 8'(i + 'h80));
    check("full_again", 32'(bus.full), 32'd1);
    op(1'b1, 1'b1, 8'hEE);
    check("full_wr_rd_count", 32'(bus.count), 32'd15);

    // wr+rd at empty accepts only the write.
    while (model_q.size() > 0) op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h77);
    check("empty_wr_rd_count", 32'(bus.count),    32'd1);
    check("empty_wr_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Reset at count=7 right after a read.
    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 8'(i + 'h90));
    op(1'b0, 1'b1, 8'h00);
    check("pre_rst_count", 32'(bus.count), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    exp_dout = 8'h00;
    $display("mid-stream reset applied");
    check("mrst_count",    32'(bus.count),    32'd0);
    check("mrst_empty",    32'(bus.empty),    32'd1);
    check("mrst_dout",     32'(bus.dout),     32'd0);
    check("mrst_rd_valid", 32'(bus.rd_valid), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("mrst_overflow",  32'(bus.overflow),  32'd0);
    check("mrst_underflow", 32'(bus.underflow), 32'd0);
`endif
    op(1'b1, 1'b0, 8'h5A);
    op(1'b0, 1'b1, 8'h00);
    check("post_rst_dout", 32'(bus.dout), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
